keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Scans a ROWS x COLS passive key matrix: drives one column low at a time, samples the row lines,
//  debounces, and presents one key code per press through a valid/ack handshake.
//  It is the input-side counterpart of the 7-segment anode/segment scan drive: it sits between the
//  board pins and the core, replacing per-button BTN_FILTER instances for matrix keypads.
// PARAMETERS
//  ROWS      4      number of row inputs (pulled up on board, low = pressed)
//  COLS      4      number of column outputs (active-low drive)
//  SCAN_DIV  50000  clk cycles per column dwell; rows are sampled on the last cycle of a dwell
//  DEBOUNCE  4      consecutive matching samples required to accept a press or a release (>=1)
//  KW        $clog2(ROWS*COLS)  key code width (localparam, not overridable)
// PORTS
//  clk        in   1     system clock
//  rst_n      in   1     asynchronous reset, active low
//  row        in   ROWS  raw row lines, async to clk, active low
//  col        out  COLS  column drive, exactly one bit low while scanning/holding, others high
//  key_code   out  KW    accepted key = row_index*COLS + col_index
//  key_valid  out  1     high from accept until the cycle after key_ack
//  key_ack    in   1     consumer acknowledge; clears key_valid
//  key_held   out  1     high while the accepted key is still physically down (PRESSED/RELEASE states)
//  overrun    out  1     sticky: a key was accepted while key_valid was already high; cleared by key_ack
// BEHAVIOUR
//  Reset: col = {COLS{1'b1}} except col[0]=0, key_code=0, key_valid=0, key_held=0, overrun=0,
//   state=SCAN, column index 0, dwell counter 0, debounce counter 0.
//  row passes through a 2-FF synchronizer; all decisions use the synchronized value (2-cycle latency).
//  Dwell counter counts 0..SCAN_DIV-1; "sample" = cycle where counter == SCAN_DIV-1, then wraps to 0.
//  States:
//   SCAN:     on sample, if any row low -> latch col index and lowest-index low row, dbc=1, go DEBOUNCE
//             (column not advanced); else advance column, wrap COLS-1 -> 0.
//   DEBOUNCE: on sample, same row still low -> dbc++; when dbc reaches DEBOUNCE -> accept, go PRESSED.
//             Latched row high -> back to SCAN, advance column. DEBOUNCE=1 accepts on the first sample.
//   PRESSED:  column held; key_held=1. On sample with latched row high -> dbc=1, go RELEASE.
//   RELEASE:  on sample, row high -> dbc++; at DEBOUNCE -> SCAN, advance column, key_held=0.
//             Row low again -> back to PRESSED (bounce, no new accept).
//  Accept (registered, 1 cycle after the accepting sample): if key_valid=0 or key_ack=1 this cycle ->
//   key_code <= new code, key_valid <= 1. Else new key dropped, key_code kept, overrun <= 1.
//  key_ack with key_valid=1 and no simultaneous accept -> key_valid <= 0, overrun <= 0 next cycle.
//  key_ack while key_valid=0 is ignored. Ack and accept in the same cycle: valid stays 1, new code
//   loaded, overrun cleared.
//  Other keys pressed while one is held are ignored (no scan during PRESSED/RELEASE); no n-key rollover.
//  Keys in other rows of the same column during DEBOUNCE do not change the latched row.
//  Reset asserted mid-press: all state cleared; on release of reset a still-held key is re-detected
//   and re-accepted as a new press.
// CONFIGURATION
//  KEYPAD_REPEAT_EN defined: in PRESSED, after 32 samples held, an accept is re-issued every 8 samples
//   (typematic); repeats obey the same valid/ack/overrun rules. Counter resets on entry to PRESSED.
//  Not defined: exactly one accept per press, regardless of hold time; repeat counter not synthesized.
// TESTING  (ROWS=COLS=4, SCAN_DIV=4, DEBOUNCE=2)
//  Reset then idle 64 cycles, no rows low -> col cycles 1110,1101,1011,0111 each 4 cycles; key_valid=0.
//  Hold row[2] low while col=1101 (col1), stable -> key_valid=1, key_code=9, key_held=1; ack -> valid=0.
//  Row low for one sample only (bounce) -> no key_valid, scan resumes at next column.
//  Accept key 5, no ack, release, press key 14 -> key_code stays 5, overrun=1; ack -> both clear.
//  Release key with 1-sample high glitch -> stays PRESSED, no second accept; clean release -> key_held=0.
//  KEYPAD_REPEAT_EN: hold key 0 for 60 samples, ack each -> accepts at samples 2, 34, 42, 50, 58.

Source files
------------

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - ROWS x COLS key matrix scanner with debounce and valid/ack key output
//
// Purpose: drives one column low at a time, samples the (synchronized) row lines once per
// column dwell, debounces press and release, and hands one key code per press to the core.
//
// Ports:
//   clk        in   1     system clock
//   rst_n      in   1     asynchronous reset, active low
//   row        in   ROWS  raw row lines, async to clk, low = pressed
//   col        out  COLS  column drive, exactly one bit low
//   key_code   out  KW    accepted key = row_index*COLS + col_index
//   key_valid  out  1     high from accept until the cycle after key_ack
//   key_ack    in   1     consumer acknowledge
//   key_held   out  1     accepted key still physically down
//   overrun    out  1     sticky: key accepted while key_valid was high; cleared by key_ack
//
// Optional feature macro: KEYPAD_REPEAT_EN (typematic repeat while a key stays held).
module keypad_scanner #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4,
  localparam int KW      = $clog2(ROWS * COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  input  logic            key_ack,
  output logic            key_held,
  output logic            overrun
);

  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DBW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_t;

  state_t          state_q, state_d;
  logic [ROWS-1:0] row_meta_q, row_meta_d;
  logic [ROWS-1:0] row_sync_q, row_sync_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [CW-1:0]   col_idx_q, col_idx_d;
  logic [RW-1:0]   row_idx_q, row_idx_d;
  logic [DBW-1:0]  dbc_q, dbc_d;
  logic [KW-1:0]   key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            overrun_q, overrun_d;
`ifdef KEYPAD_REPEAT_EN
  logic [5:0]      rpt_q, rpt_d;
`endif

  logic            sample;
  logic            any_low;
  logic [RW-1:0]   low_idx;
  logic [RW-1:0]   row_sel;
  logic            row_low;
  logic            accept;
  logic [CW-1:0]   col_next;
  logic [KW-1:0]   code_new;

  // Two-stage synchronizer for the asynchronous row lines.
  always_comb begin
    row_meta_d = row;
    row_sync_d = row_meta_q;
  end

  // Column dwell timer; rows are only looked at on the last cycle of each dwell.
  always_comb begin
    sample  = (dwell_q == DW'(SCAN_DIV - 1));
    dwell_d = sample ? '0 : dwell_q + DW'(1);
  end

  // Lowest-index pressed row: iterate downwards so the smallest index wins.
  always_comb begin
    any_low = 1'b0;
    low_idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!row_sync_q[i]) begin
        any_low = 1'b1;
        low_idx = RW'(i);
      end
    end
  end

  always_comb begin
    col_next = (col_idx_q == CW'(COLS - 1)) ? '0 : col_idx_q + CW'(1);
    row_low  = !row_sync_q[row_idx_q];
    // In SCAN the row is not latched yet (only matters when DEBOUNCE accepts on detection).
    row_sel  = (state_q == ST_SCAN) ? low_idx : row_idx_q;
    code_new = KW'(int'(row_sel) * COLS + int'(col_idx_q));
  end

  // Scan / debounce state machine.
  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    dbc_d     = dbc_q;
    accept    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_d     = rpt_q;
`endif
    if (sample) begin
      case (state_q)
        ST_SCAN: begin
          if (any_low) begin
            row_idx_d = low_idx;
            dbc_d     = DBW'(1);
            if (DEBOUNCE <= 1) begin
              accept  = 1'b1;
              state_d = ST_PRESSED;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end else begin
            col_idx_d = col_next;
          end
        end
        ST_DEBOUNCE: begin
          // Only the latched row counts; other rows of this column are ignored.
          if (row_low) begin
            if (int'(dbc_q) + 1 >= DEBOUNCE) begin
              accept  = 1'b1;
              state_d = ST_PRESSED;
            end else begin
              dbc_d = dbc_q + DBW'(1);
            end
          end else begin
            state_d   = ST_SCAN;
            col_idx_d = col_next;
          end
        end
        ST_PRESSED: begin
          if (!row_low) begin
            if (DEBOUNCE <= 1) begin
              state_d   = ST_SCAN;
              col_idx_d = col_next;
            end else begin
              dbc_d   = DBW'(1);
              state_d = ST_RELEASE;
            end
          end
`ifdef KEYPAD_REPEAT_EN
          // First repeat on the 32nd held sample, then every 8 samples.
          else if (rpt_q == 6'd31) begin
            accept = 1'b1;
            rpt_d  = 6'd24;
          end else begin
            rpt_d = rpt_q + 6'd1;
          end
`endif
        end
        ST_RELEASE: begin
          if (!row_low) begin
            if (int'(dbc_q) + 1 >= DEBOUNCE) begin
              state_d   = ST_SCAN;
              col_idx_d = col_next;
            end else begin
              dbc_d = dbc_q + DBW'(1);
            end
          end else begin
            state_d = ST_PRESSED;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
`ifdef KEYPAD_REPEAT_EN
    if (state_q != ST_PRESSED && state_d == ST_PRESSED) begin
      rpt_d = '0;
    end
`endif
  end

  // Output handshake: an ack in the same cycle frees the slot for a new accept.
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    if (accept) begin
      if (!key_valid_q || key_ack) begin
        key_code_d  = code_new;
        key_valid_d = 1'b1;
        if (key_ack) begin
          overrun_d = 1'b0;
        end
      end else begin
        overrun_d = 1'b1;
      end
    end else if (key_ack && key_valid_q) begin
      key_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SCAN;
      row_meta_q  <= '1;
      row_sync_q  <= '1;
      dwell_q     <= '0;
      col_idx_q   <= '0;
      row_idx_q   <= '0;
      dbc_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      row_meta_q  <= row_meta_d;
      row_sync_q  <= row_sync_d;
      dwell_q     <= dwell_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      dbc_q       <= dbc_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      overrun_q   <= overrun_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_q       <= rpt_d;
`endif
    end
  end

  assign col       = ~(COLS'(1) << col_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign overrun   = overrun_q;
  assign key_held  = (state_q == ST_PRESSED) || (state_q == ST_RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with a modelled key matrix
module tb_keypad_scanner;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       overrun;
  logic       key_ack;
  logic       ack_auto = 1'b0;
  logic       ack_man = 1'b0;
  logic       auto_ack = 1'b0;
  logic       key_down = 1'b0;
  logic [3:0] key_sel = 4'd0;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  assign key_ack = ack_auto | ack_man;

  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its row low only while its column is driven low.
  always_comb begin
    row = 4'hF;
    if (key_down && !col[key_sel[1:0]]) row[key_sel[3:2]] = 1'b0;
  end

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .key_code(key_code),
    .key_valid(key_valid), .key_ack(key_ack), .key_held(key_held), .overrun(overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold key k for 'hold' cycles then release for 'rel' cycles (both >= 40).
  task automatic press(input logic [3:0] k, input int hold, input int rel, input bit expect_acc);
    key_sel = k;
    if (expect_acc) exp_q.push_back(int'(k));
    key_down = 1'b1;
    cyc(30);
    check("key_held_on", 32'(key_held), 1);
    cyc(hold - 30);
    key_down = 1'b0;
    cyc(rel);
    check("key_held_off", 32'(key_held), 0);
  endtask

  // Consumer: acknowledges a presented key after a random delay.
  initial forever begin
    @(negedge clk);
    if (auto_ack && key_valid && rst_n) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk);
      #1 ack_auto = 1'b1;
      @(posedge clk);
      #1 ack_auto = 1'b0;
    end
  end

  // Monitor: a key is presented when valid rises, or stays high right after an ack.
  initial begin
    logic v_prev;
    logic a_prev;
    v_prev = 1'b0;
    a_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        v_prev = 1'b0;
        a_prev = 1'b0;
      end else begin
        if (key_valid && (!v_prev || a_prev)) begin
          if (exp_q.size() == 0) check("unexpected_key", 32'(key_code), 32'hFFFF_FFFF);
          else check("key_code", 32'(key_code), exp_q.pop_front());
        end
        v_prev = key_valid;
        a_prev = key_ack;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] ec;
    logic [3:0] k;
    // Reset state
    cyc(3);
    check("rst_col", 32'(col), 32'h0000_000E);
    check("rst_code", 32'(key_code), 0);
    check("rst_valid", 32'(key_valid), 0);
    check("rst_held", 32'(key_held), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst_n = 1'b1;

    // Idle scan: each column for SCAN_DIV cycles, in order
    for (int m = 0; m < 64; m++) begin
      ec = ~(4'b0001 << ((m / SCAN_DIV) % COLS));
      check("idle_col", 32'(col), 32'(ec));
      check("idle_valid", 32'(key_valid), 0);
      cyc(1);
    end

    auto_ack = 1'b1;
    // Row 2 / column 1 -> code 9
    press(4'd9, 50, 40, 1'b1);
    check("ack_clears_valid", 32'(key_valid), 0);

    // One-sample bounce on key 10 (column 2), aligned to the column's dwell start
    for (int i = 0; i < 40 && col == 4'b1011; i++) cyc(1);
    for (int i = 0; i < 40 && col != 4'b1011; i++) cyc(1);
    check("bounce_col_reached", 32'(col), 32'h0000_000B);
    key_sel  = 4'd10;
    key_down = 1'b1;
    cyc(4);
    key_down = 1'b0;
    cyc(2);
    check("bounce_col_held", 32'(col), 32'h0000_000B);
    cyc(3);
    check("bounce_col_next", 32'(col), 32'h0000_0007);
    cyc(20);
    check("bounce_no_valid", 32'(key_valid), 0);

    // Random short glitches: never sampled twice in a row, so never accepted
    for (int i = 0; i < 4; i++) begin
      key_sel  = 4'($urandom_range(0, 15));
      key_down = 1'b1;
      cyc(4);
      key_down = 1'b0;
      cyc(20);
    end

    // Random full presses
    for (int i = 0; i < 10; i++) begin
      k = 4'($urandom_range(0, 15));
      press(k, int'($urandom_range(40, 80)), 40, 1'b1);
    end

    // Release glitch of exactly one sample: stays held, no second accept
    k = 4'($urandom_range(0, 15));
    key_sel = k;
    exp_q.push_back(int'(k));
    key_down = 1'b1;
    cyc(40);
    key_down = 1'b0;
    cyc(4);
    key_down = 1'b1;
    cyc(12);
    check("glitch_held", 32'(key_held), 1);
    cyc(20);
    key_down = 1'b0;
    cyc(40);
    check("glitch_released", 32'(key_held), 0);

    // Overrun: 5 accepted and left pending, 14 dropped
    cyc(10);
    auto_ack = 1'b0;
    cyc(2);
    press(4'd5, 40, 40, 1'b1);
    press(4'd14, 40, 40, 1'b0);
    check("ovr_valid", 32'(key_valid), 1);
    check("ovr_code_kept", 32'(key_code), 5);
    check("ovr_flag", 32'(overrun), 1);
    ack_man = 1'b1;
    cyc(1);
    ack_man = 1'b0;
    check("ovr_ack_valid", 32'(key_valid), 0);
    check("ovr_ack_flag", 32'(overrun), 0);
    auto_ack = 1'b1;

    // Reset while a key is held: re-detected as a new press afterwards
    k = 4'($urandom_range(0, 15));
    key_sel = k;
    exp_q.push_back(int'(k));
    key_down = 1'b1;
    cyc(30);
    check("pre_reset_held", 32'(key_held), 1);
    rst_n = 1'b0;
    cyc(2);
    check("mid_reset_held", 32'(key_held), 0);
    check("mid_reset_valid", 32'(key_valid), 0);
    check("mid_reset_col", 32'(col), 32'h0000_000E);
    exp_q.push_back(int'(k));
    rst_n = 1'b1;
    cyc(40);
    check("post_reset_held", 32'(key_held), 1);
    key_down = 1'b0;
    cyc(40);
    check("post_reset_released", 32'(key_held), 0);

    cyc(20);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
